rotate_sequencer: RTL and testbench

ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

---
 rtl/rotate_sequencer.sv | 84 ++++++++
 tb/tb_rotate_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
// Drives an external 8-bit rotating shift register to rotate one byte right by N (in_rot, 0 = 8).
// Latency N+2 cycles from accept to out_valid; one transaction at a time; ROTATE_SEQ_PARITY_EN adds out_parity.
module rotate_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic [2:0] in_rot,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] sr_d0,
   output logic       sr_shift,
   input  logic [7:0] sr_q,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready
`ifdef ROTATE_SEQ_PARITY_EN
   ,
   output logic       out_parity
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, ROT, HOLD} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] byte_q;
   logic       pass_sel;

   // pass_sel makes the register reload its own value (hold) in IDLE and HOLD
   assign sr_d0    = pass_sel ? sr_q : byte_q;
   assign out_data = sr_q;

`ifdef ROTATE_SEQ_PARITY_EN
   assign out_parity = out_valid & (^sr_q);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         byte_q    <= 8'h00;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         sr_shift  <= 1'b0;
         pass_sel  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               pass_sel <= 1'b1;
               // in_ready is low for the first cycle after reset, so gate the accept on it
               if (in_valid && in_ready) begin
                  byte_q   <= in_data;
                  cnt      <= (in_rot == 3'd0) ? 4'd8 : {1'b0, in_rot};
                  in_ready <= 1'b0;
                  pass_sel <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               sr_shift <= 1'b1;
               state    <= ROT;
            end
            ROT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  sr_shift  <= 1'b0;
                  out_valid <= 1'b1;
                  pass_sel  <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer; models the downstream rotating shift register.
module tb_rotate_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic [2:0] in_rot;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sr_d0;
   logic       sr_shift;
   logic [7:0] sr_q = 8'h00;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
`ifdef ROTATE_SEQ_PARITY_EN
   logic       out_parity;
`endif

   int n_vec = 0;
   int n_bad = 0;

   rotate_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_rot    (in_rot),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sr_d0     (sr_d0),
      .sr_shift  (sr_shift),
      .sr_q      (sr_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ROTATE_SEQ_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   // downstream register: Q[i] <= Q[i+1 mod 8] when shifting, else load
   always @(posedge clk) sr_q <= sr_shift ? {sr_q[0], sr_q[7:1]} : sr_d0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // accept one byte and follow it to the first HOLD cycle (returns at that negedge)
   task automatic do_txn(input logic [7:0] data, input logic [2:0] rot, input int n,
                         input logic [7:0] exp);
      int  shifts;
      int  lat;
      bit  found;
      shifts = 0;
      lat    = 0;
      found  = 0;
      @(negedge clk);
      chk("rdy_pre", {31'd0, in_ready}, 32'd1);
      in_data  = data;
      in_rot   = rot;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 20 && !found; k++) begin
         @(negedge clk);
         if (sr_shift) shifts++;
         if (out_valid) begin
            lat   = k;
            found = 1;
         end
      end
      chk("latency", lat, n + 2);
      chk("shifts", shifts, n);
      chk("out_data", {24'd0, out_data}, {24'd0, exp});
`ifdef ROTATE_SEQ_PARITY_EN
      chk("parity", {31'd0, out_parity}, {31'd0, ^exp});
`endif
   endtask

   // with out_ready=1 at a HOLD negedge: complete handshake and check return to IDLE
   task automatic finish_hs();
      chk("rdy_in_hold", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("rdy_after", {31'd0, in_ready}, 32'd1);
      chk("ov_after", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      in_data   = 8'h00;
      in_rot    = 3'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sr_shift", {31'd0, sr_shift}, 32'd0);
      chk("rst_sr_d0", {24'd0, sr_d0}, 32'h00);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rdy_before_edge", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("rdy_first_edge", {31'd0, in_ready}, 32'd1);

      // 0xA5 >> 1 rotate
      do_txn(8'hA5, 3'd1, 1, 8'hD2);
      finish_hs();

      // count 0 means 8: byte returns unchanged
      do_txn(8'h81, 3'd0, 8, 8'h81);
      finish_hs();

      // consumer stalls 5 cycles; stray in_valid pulses must be ignored
      out_ready = 1'b0;
      do_txn(8'h0F, 3'd4, 4, 8'hF0);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = 8'h3C;
         in_rot   = 3'd2;
         @(negedge clk);
         chk("stall_data", {24'd0, out_data}, 32'hF0);
         chk("stall_rdy", {31'd0, in_ready}, 32'd0);
         chk("stall_ov", {31'd0, out_valid}, 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      finish_hs();

      // reset asserted during the 2nd ROT cycle
      @(negedge clk);
      in_data  = 8'h33;
      in_rot   = 3'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("mid_rot_shift", {31'd0, sr_shift}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_shift", {31'd0, sr_shift}, 32'd0);
      chk("abort_ov", {31'd0, out_valid}, 32'd0);
      chk("abort_rdy", {31'd0, in_ready}, 32'd0);
      chk("abort_d0", {24'd0, sr_d0}, 32'h00);
      chk("abort_out_q", {24'd0, out_data}, {24'd0, sr_q});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("abort_ov_hold", {31'd0, out_valid}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rdy_post_abort", {31'd0, in_ready}, 32'd1);
      do_txn(8'h01, 3'd1, 1, 8'h80);
      finish_hs();

      do_txn(8'h07, 3'd3, 3, 8'hE0);
      finish_hs();
`ifdef ROTATE_SEQ_PARITY_EN
      chk("parity_idle", {31'd0, out_parity}, 32'd0);
`endif

      // back-to-back transactions
      do_txn(8'h01, 3'd2, 2, 8'h40);
      finish_hs();
      do_txn(8'h02, 3'd7, 7, 8'h04);
      finish_hs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
